// File: rtl/bound_flasher_pkg.sv
// Shared types and constants for the Bound Flasher: state encoding,
// LED bar size and the direction helpers used by the LED/count register.
package bound_flasher_pkg;

  localparam int N_LED = 16;
  localparam int CNT_W = $clog2(N_LED + 1);

  typedef enum logic [2:0] {
    ST_INITIAL = 3'd0,
    ST_0_TO_15 = 3'd1,
    ST_15_TO_5 = 3'd2,
    ST_5_TO_10 = 3'd3,
    ST_10_TO_0 = 3'd4,
    ST_0_TO_5  = 3'd5,
    ST_5_TO_0  = 3'd6
  } state_t;

  function automatic logic is_up(state_t st);
    case (st)
      ST_0_TO_15, ST_5_TO_10, ST_0_TO_5: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_down(state_t st);
    case (st)
      ST_15_TO_5, ST_10_TO_0, ST_5_TO_0: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flk_synchronizer.sv
// Multi-flop level synchroniser for the asynchronous flick button.
// Output is the last flop of a SYNC_FF-deep chain; no edge detection.
module flk_synchronizer #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_FF-1:0] sync_q;
  logic [SYNC_FF-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_FF-2:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_FF-1];

endmodule

// File: rtl/state_led_register.sv
// Bound Flasher state register plus LED thermometer bar and lit-LED count.
// LED/count move one step per edge in the direction of the state held before that edge.
module state_led_register
  import bound_flasher_pkg::*;
#(
  parameter int SYNC_FF = 2
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             flk_in,
  input  logic [2:0]       nxt_st,
  output logic             flk_sync,
  output logic [2:0]       cur_st,
  output logic [CNT_W-1:0] count,
  output logic [N_LED-1:0] led,
  output logic             busy
);

  state_t             cur_st_q, cur_st_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [N_LED-1:0]   led_q, led_d;

  flk_synchronizer #(.SYNC_FF(SYNC_FF)) u_flk_sync (
    .clk      (div_clk),
    .rst      (rst),
    .async_in (flk_in),
    .sync_out (flk_sync)
  );

  always_comb begin
    cur_st_d = ST_INITIAL;
    count_d  = count_q;
    led_d    = led_q;

    // The unused encoding 7 falls back to idle instead of propagating.
    if (nxt_st == 3'd7) begin
      cur_st_d = ST_INITIAL;
    end else begin
      cur_st_d = state_t'(nxt_st);
    end

    if (cur_st_q == ST_INITIAL) begin
      count_d = count_q;
      led_d   = led_q;
    end else if (is_up(cur_st_q)) begin
      led_d   = {led_q[N_LED-2:0], 1'b1};
      count_d = (count_q == CNT_W'(N_LED)) ? count_q : count_q + CNT_W'(1);
    end else if (is_down(cur_st_q)) begin
      led_d   = {1'b0, led_q[N_LED-1:1]};
      count_d = (count_q == CNT_W'(0)) ? count_q : count_q - CNT_W'(1);
    end else begin
      led_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge div_clk) begin
    if (rst) begin
      cur_st_q <= ST_INITIAL;
      count_q  <= '0;
      led_q    <= '0;
    end else begin
      cur_st_q <= cur_st_d;
      count_q  <= count_d;
      led_q    <= led_d;
    end
  end

  assign cur_st = cur_st_q;
  assign count  = count_q;
  assign led    = led_q;
  assign busy   = (cur_st_q != ST_INITIAL);

endmodule
